// File: rtl/icache_pkg.sv
// Shared types, default parameters and width helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS,
    S_REFILL,
    S_WRITE
  } state_e;

  localparam int unsigned DEF_WAYS       = 2;
  localparam int unsigned DEF_SETS       = 64;
  localparam int unsigned DEF_LINE_BYTES = 16;
  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_MEM_W      = 64;
  localparam int unsigned WORD_W         = 32;

  // Field width that stays at least one bit wide for degenerate sizes
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_sa_if.sv
// Fetch-side and memory-side handshake bundle of the instruction cache.
interface icache_sa_if
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned MEM_W  = DEF_MEM_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic [WORD_W-1:0] resp_data;
  logic              flush;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid;
  logic              mem_resp_ready;
  logic [MEM_W-1:0]  mem_resp_data;

  // Cache side
  modport slave (
    input  req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    output req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr, mem_resp_ready
  );

  // Fetch stage plus memory bus side
  modport master (
    output req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr, mem_resp_ready
  );

endinterface

// File: rtl/icache_way_ram.sv
// One cache way: single-port synchronous-read RAM holding {tag, line} per set.
module icache_way_ram
  import icache_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_SETS,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         en_i,
  input  logic                         we_i,
  input  logic [clog2_min1(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Read output holds its value while the port is idle or writing
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_o <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/icache_sa.sv
// N-way set-associative read-only instruction cache with multi-beat line refill,
// invalid-first/round-robin replacement and whole-cache flush.
module icache_sa
  import icache_pkg::*;
#(
  parameter int unsigned WAYS       = DEF_WAYS,
  parameter int unsigned SETS       = DEF_SETS,
  parameter int unsigned LINE_BYTES = DEF_LINE_BYTES,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned MEM_W      = DEF_MEM_W
) (
  input logic        clk,
  input logic        rst,
  icache_sa_if.slave bus
);

  localparam int unsigned OFFSET_W = $clog2(LINE_BYTES);
  localparam int unsigned INDEX_W  = $clog2(SETS);
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned WOFF_W   = OFFSET_W - 2;
  localparam int unsigned LINE_W   = LINE_BYTES * 8;
  localparam int unsigned BEATS    = LINE_W / MEM_W;
  localparam int unsigned BEAT_W   = clog2_min1(BEATS);
  localparam int unsigned WAY_W    = clog2_min1(WAYS);
  localparam int unsigned ENTRY_W  = TAG_W + LINE_W;

  state_e                         state_q, state_d;
  logic [TAG_W-1:0]               tag_q, tag_d;
  logic [INDEX_W-1:0]             idx_q, idx_d;
  logic [WOFF_W-1:0]              woff_q, woff_d;
  logic [BEAT_W-1:0]              beat_q, beat_d;
  logic [LINE_W-1:0]              line_q, line_d;
  logic                           flush_pend_q, flush_pend_d;
  logic [WAYS-1:0][SETS-1:0]      valid_q, valid_d;
  logic [SETS-1:0][WAY_W-1:0]     rr_q, rr_d;

  logic [TAG_W-1:0]               req_tag;
  logic [INDEX_W-1:0]             req_idx;
  logic [WOFF_W-1:0]              req_woff;
  logic                           unused_addr_lsb;

  logic [WAYS-1:0][ENTRY_W-1:0]   rd_entry;
  logic                           ram_en;
  logic [WAYS-1:0]                ram_we;
  logic [INDEX_W-1:0]             ram_addr;

  logic                           hit;
  logic [LINE_W-1:0]              hit_line;
  logic [WAY_W-1:0]               victim;
  logic                           accept;

  logic                           req_ready_c;
  logic                           resp_valid_c;
  logic [WORD_W-1:0]              resp_data_c;
  logic                           mem_req_valid_c;
  logic                           mem_resp_ready_c;

  function automatic logic [WORD_W-1:0] pick_word(input logic [LINE_W-1:0] line,
                                                  input logic [WOFF_W-1:0] woff);
    return WORD_W'(line >> {woff, 5'b00000});
  endfunction

  assign req_tag         = bus.req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx         = bus.req_addr[OFFSET_W +: INDEX_W];
  assign req_woff        = bus.req_addr[2 +: WOFF_W];
  assign unused_addr_lsb = ^bus.req_addr[1:0];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    icache_way_ram #(
      .DEPTH (SETS),
      .WIDTH (ENTRY_W)
    ) u_ram (
      .clk     (clk),
      .en_i    (ram_en),
      .we_i    (ram_we[g]),
      .addr_i  (ram_addr),
      .wdata_i ({tag_q, line_q}),
      .rdata_o (rd_entry[g])
    );
  end

  // Tag compare across all ways; descending scan so the lowest hitting way wins
  always_comb begin
    hit      = 1'b0;
    hit_line = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][idx_q] && (rd_entry[w][LINE_W +: TAG_W] == tag_q)) begin
        hit      = 1'b1;
        hit_line = rd_entry[w][LINE_W-1:0];
      end
    end
  end

  // Lowest invalid way first, otherwise the set's round-robin pointer
  always_comb begin
    victim = rr_q[idx_q];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][idx_q]) begin
        victim = WAY_W'(w);
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d          = state_q;
    tag_d            = tag_q;
    idx_d            = idx_q;
    woff_d           = woff_q;
    beat_d           = beat_q;
    line_d           = line_q;
    flush_pend_d     = flush_pend_q;
    valid_d          = valid_q;
    rr_d             = rr_q;
    req_ready_c      = 1'b0;
    resp_valid_c     = 1'b0;
    resp_data_c      = '0;
    mem_req_valid_c  = 1'b0;
    mem_resp_ready_c = 1'b0;
    ram_en           = 1'b0;
    ram_we           = '0;
    ram_addr         = req_idx;
    accept           = 1'b0;

    unique case (state_q)
      S_IDLE:   req_ready_c = !bus.flush;
      S_LOOKUP: begin
        if (hit) begin
          req_ready_c  = 1'b1;
          resp_valid_c = 1'b1;
          resp_data_c  = pick_word(hit_line, woff_q);
        end
      end
      S_MISS:   mem_req_valid_c = 1'b1;
      S_REFILL: mem_resp_ready_c = 1'b1;
      S_WRITE: begin
        resp_valid_c = 1'b1;
        resp_data_c  = pick_word(line_q, woff_q);
      end
      default: ;
    endcase

    accept = bus.req_valid && req_ready_c;
    if (accept) begin
      tag_d  = req_tag;
      idx_d  = req_idx;
      woff_d = req_woff;
      ram_en = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (!hit) begin
          state_d = S_MISS;
        end else if (!accept) begin
          state_d = S_IDLE;
        end
      end
      S_MISS: begin
        if (bus.mem_req_ready) begin
          state_d = S_REFILL;
          beat_d  = '0;
        end
      end
      S_REFILL: begin
        if (bus.mem_resp_valid) begin
          for (int k = 0; k < BEATS; k++) begin
            if (beat_q == BEAT_W'(k)) line_d[k*MEM_W +: MEM_W] = bus.mem_resp_data;
          end
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(BEATS - 1)) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        ram_en                 = 1'b1;
        ram_addr               = idx_q;
        ram_we[victim]         = 1'b1;
        valid_d[victim][idx_q] = 1'b1;
        rr_d[idx_q]            = (WAYS > 1) ? rr_q[idx_q] + WAY_W'(1) : '0;
        flush_pend_d           = 1'b0;
        state_d                = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A flush during refill is deferred so the line being fetched is dropped too
    if (bus.flush) begin
      if (state_q == S_MISS || state_q == S_REFILL) begin
        flush_pend_d = 1'b1;
      end else begin
        valid_d = '0;
      end
    end
    if (state_q == S_WRITE && flush_pend_q) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tag_q        <= '0;
      idx_q        <= '0;
      woff_q       <= '0;
      beat_q       <= '0;
      line_q       <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      rr_q         <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      idx_q        <= idx_d;
      woff_q       <= woff_d;
      beat_q       <= beat_d;
      line_q       <= line_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      rr_q         <= rr_d;
    end
  end

  assign bus.req_ready      = req_ready_c;
  assign bus.resp_valid     = resp_valid_c;
  assign bus.resp_data      = resp_data_c;
  assign bus.mem_req_valid  = mem_req_valid_c;
  assign bus.mem_req_addr   = {tag_q, idx_q, OFFSET_W'(0)};
  assign bus.mem_resp_ready = mem_resp_ready_c;

endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised N-way set-associative, read-only instruction cache between the fetch stage and the memory bus.
- Adds over the current fixed 2-way cache: configurable ways, sets and line size; multi-beat line refill; invalid-first plus round-robin replacement; back-to-back hits at one per cycle; whole-cache invalidate for `fence.i`.
- Hits return in one cycle. Misses refill a full line over a valid/ready memory port.

## Interface
Parameters:
- `WAYS`, 2, associativity; power of two, ≥1.
- `SETS`, 64, sets per way; power of two.
- `LINE_BYTES`, 16, line size; power of two; `LINE_BYTES*8 ≥ MEM_W`.
- `ADDR_W`, 32, address width.
- `MEM_W`, 64, refill beat width; `BEATS = LINE_BYTES*8/MEM_W`.

Ports:
- Clocking and reset (already decided): reset `rst`, synchronous, active-high; clock `clk`.
- `clk` in 1: clock.
- `rst` in 1: reset.
- `req_valid` in 1: fetch request.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_addr` in `ADDR_W`: fetch address; bits [1:0] ignored.
- `resp_valid` out 1: one-cycle pulse, `resp_data` valid. There is no back-pressure; fetch always accepts.
- `resp_data` out 32: instruction word.
- `flush` in 1: invalidate all lines.
- `mem_req_valid` out 1 / `mem_req_ready` in 1: line read request handshake.
- `mem_req_addr` out `ADDR_W`: line-aligned address, low `OFFSET_W` bits zero.
- `mem_resp_valid` in 1 / `mem_resp_ready` out 1: refill beat handshake.
- `mem_resp_data` in `MEM_W`: refill beat, lowest address first.

## Operation
Address fields:
- `OFFSET_W = log2(LINE_BYTES)`, `INDEX_W = log2(SETS)`, `TAG_W = ADDR_W - INDEX_W - OFFSET_W`.
- Address layout is {tag, index, offset}.

Storage:
- Valid bits live in flops, `WAYS×SETS`.
- Tag and data arrays are synchronous-read RAMs, one per way.
- Each set has a round-robin victim pointer (`log2(WAYS)` bits).

FSM states:
- `IDLE`: `req_ready=1`. On accept, go to `LOOKUP` and latch tag, index and offset. RAMs are read at the request index.
- `LOOKUP`: compare all ways.
  - Hit: `resp_valid=1`, `resp_data` is the selected word, `req_ready=1`. A new accept stays in `LOOKUP`; otherwise go to `IDLE`.
  - Miss: `req_ready=0`, go to `MISS`.
- `MISS`: `mem_req_valid=1` with the line address. Valid and address stay stable until `mem_req_ready`, then go to `REFILL`.
- `REFILL`: `mem_resp_ready=1`. Each beat k is stored at refill-buffer bits [k·MEM_W +: MEM_W]. After beat `BEATS-1`, go to `WRITE`.
- `WRITE`: write the line, tag and valid=1 into the victim way. Pulse `resp_valid` with the requested word taken from the refill buffer, then go to `IDLE`.

Victim selection:
- Lowest-indexed invalid way in the set.
- If all ways are valid, use the set's round-robin pointer. The pointer increments, modulo `WAYS`, on every fill of that set.

Flush:
- In `IDLE`, `LOOKUP` or `WRITE`, clear all valid bits in the same edge.
- During `MISS` or `REFILL`, the flush is latched and applied at the `WRITE` edge, so the new line also ends up invalid. The response is still delivered.
- A flush in `IDLE` together with `req_valid`: flush wins and `req_ready=0` that cycle.
- A hit in `LOOKUP` that coincides with a flush is still returned.

Boundary rules:
- `mem_resp_valid` outside `REFILL` is ignored.
- If multiple ways hit, the lowest way is used (not expected in normal operation).

## Timing
Reset values:
- state `IDLE`, all valid bits 0, pointers 0.
- `req_ready=1`, `resp_valid=0`, `mem_req_valid=0`, `mem_resp_ready=0`.

Reset mid-operation:
- Reset during `MISS`/`REFILL` aborts the refill, and nothing is written.

Latency:
- Hit: request accepted at cycle T gives `resp_valid` at T+1. Sustained throughput is one hit per cycle.
- Miss: accept at T, `LOOKUP` at T+1, `mem_req_valid` from T+2. Response comes one cycle after the last beat handshake.
- Miss latency = 3 + request wait + beat cycles.

Output registration:
- All outputs are decoded from registered state or read from RAM outputs.
- There are no combinational paths from `mem_*` inputs to `req_ready` or `resp_valid`.

## Structure
- Shared package `icache_pkg`: FSM state encoding, default parameter values, and the `clog2`-derived width helpers.
- Sub-module `icache_way_ram`: single-port, synchronous-read, `SETS`-deep RAM holding `{tag, line}`, with a write enable. The cache instantiates `WAYS` copies.

## Test plan
Default parameters give `BEATS=2`, `TAG_W=22`.
- **Cold miss:** reset, then request 0x8000_0004. Required: `mem_req_addr=0x8000_0000`. Beats 0x11111111_00000000 then 0x33333333_22222222 return `resp_data=0x11111111`, one cycle after the second beat.
- **Back-to-back hits:** requests 0x8000_0000, 0x8000_0008, 0x8000_000C on consecutive cycles. Required: three `resp_valid` pulses on consecutive cycles with 0x00000000, 0x22222222, 0x33333333, and no `mem_req_valid`.
- **Replacement:** fill tags A, B, C into index 5. Required: C replaces way 0, where A was. A then misses, and B still hits.
- **Flush:** flush after filling. Required: the next request to the same address misses. Also, a flush during `REFILL` still delivers the response, but the line misses afterward.
- **Memory back-pressure and reset:** hold `mem_req_ready=0` for 10 cycles. Required: address stable, `req_ready=0`. Asserting `rst` during `REFILL` returns all outputs to reset values, and the line is not valid.
